stopwatch_ctrl: RTL

Run/pause/lap/clear sequencer for the stopwatch `Timer`. It turns two raw DE10 push-buttons into clean press events and drives the timer's `en` and clear. It freezes a lap snapshot of `sec`/`tenth_sec` for the display. It sits between the board keys and `Timer`; its display outputs feed the seven-segment decoders.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_ctrl_key_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and widths for the stopwatch run/pause/lap/clear controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } sw_state_t;

   localparam int SEC_W   = 6;
   localparam int TENTH_W = 4;

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Two-flop synchronizer, stable-count debouncer and press-edge detector
// for one active-low push-button.
module key_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic             level_prev_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg      <= 1'b1;
         sync2_reg      <= 1'b1;
         level_reg      <= 1'b1;
         level_prev_reg <= 1'b1;
         cnt_reg        <= '0;
      end else begin
         sync1_reg      <= key_n;
         sync2_reg      <= sync1_reg;
         level_prev_reg <= level_reg;
         // Any cycle that agrees with the accepted level restarts the count.
         if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   // Released (1) to pressed (0) transition of the debounced level.
   assign press = level_prev_reg & ~level_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced start/lap keys drive the timer enable/clear
// and select between live time and a frozen lap snapshot for the display.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key_start_n,
   input  logic               key_lap_n,
   input  logic [SEC_W-1:0]   sec,
   input  logic [TENTH_W-1:0] tenth_sec,
   output logic               timer_en,
   output logic               timer_clr,
   output logic [SEC_W-1:0]   disp_sec,
   output logic [TENTH_W-1:0] disp_tenth,
   output logic               lap_active,
   output logic [1:0]         state
);

   logic start_ev;
   logic lap_ev;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_start_n),
      .press (start_ev)
   );

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_lap_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_lap_n),
      .press (lap_ev)
   );

   sw_state_t          state_reg, state_next;
   logic               clr_reg, clr_next;
   logic               lap_capture, lap_zero;
   logic [SEC_W-1:0]   lap_sec_reg;
   logic [TENTH_W-1:0] lap_tenth_reg;
   logic [SEC_W-1:0]   disp_sec_reg;
   logic [TENTH_W-1:0] disp_tenth_reg;

   // Start is tested first everywhere so a simultaneous lap event is dropped.
   always_comb begin
      state_next  = state_reg;
      clr_next    = 1'b0;
      lap_capture = 1'b0;
      lap_zero    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_ev) state_next = RUN;
         end
         RUN: begin
            if (start_ev) begin
               state_next = PAUSE;
            end else if (lap_ev) begin
               state_next  = LAP;
               lap_capture = 1'b1;
            end
         end
         LAP: begin
            if (start_ev)    state_next = PAUSE;
            else if (lap_ev) state_next = RUN;
         end
         PAUSE: begin
            if (start_ev) begin
               state_next = RUN;
            end else if (lap_ev) begin
               state_next = IDLE;
               clr_next   = 1'b1;
               lap_zero   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         clr_reg        <= 1'b0;
         lap_sec_reg    <= '0;
         lap_tenth_reg  <= '0;
         disp_sec_reg   <= '0;
         disp_tenth_reg <= '0;
      end else begin
         state_reg <= state_next;
         clr_reg   <= clr_next;
         if (lap_capture) begin
            lap_sec_reg   <= sec;
            lap_tenth_reg <= tenth_sec;
         end else if (lap_zero) begin
            lap_sec_reg   <= '0;
            lap_tenth_reg <= '0;
         end
         if (state_reg == LAP) begin
            disp_sec_reg   <= lap_sec_reg;
            disp_tenth_reg <= lap_tenth_reg;
         end else begin
            disp_sec_reg   <= sec;
            disp_tenth_reg <= tenth_sec;
         end
      end
   end

   assign timer_en   = (state_reg == RUN) || (state_reg == LAP);
   assign lap_active = (state_reg == LAP);
   assign state      = state_reg;
   assign timer_clr  = clr_reg;
   assign disp_sec   = disp_sec_reg;
   assign disp_tenth = disp_tenth_reg;

endmodule
